rr_arbiter4: RTL and testbench

//  Round-robin arbiter sharing one resource among 4 requesters. Registers a 2-bit

---
 rtl/rr_arbiter4_pkg.sv | 21 ++
 rtl/rr_arbiter4_if.sv | 14 +
 rtl/rr_arbiter4_grant_decode.sv | 12 +
 rtl/rr_arbiter4.sv | 86 ++++++++
 tb/tb_rr_arbiter4.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared sizes, FSM state type and the rotating-priority pick function
package arb4_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

    // Returns {found, idx}: first set request scanning upward from ptr, wrapping 3 -> 0
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = ptr + IDX_W'(i);
            r = req[j] ? {1'b1, j} : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between the requesters (master) and the arbiter (slave)
interface rr_arbiter4_if;
    import arb4_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             timeout;

    modport master (output req, input grant, grant_idx, grant_vld, timeout);
    modport slave  (input req, output grant, grant_idx, grant_vld, timeout);

endinterface

// File: rtl/rr_arbiter4_grant_decode.sv
// grant_decode: enabled 2-to-4 decoder turning the owner index into a one-hot grant
module grant_decode
    import arb4_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_o
);

    assign grant_o = en_i ? N_REQ'(1) << idx_i : '0;

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter; define ARB_TIMEOUT_EN to revoke grants held MAX_HOLD cycles
module rr_arbiter4
    import arb4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst_n,
    rr_arbiter4_if.slave bus
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   pick;
    logic             hold_exp;

    assign pick = rr_pick(bus.req, ptr_q);

    // FSM state, current owner index and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Owner keeps the grant until it drops req or the hold limit hits; otherwise arbitrate
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (state_q == GRANT) begin
            state_d = (!bus.req[idx_q] || hold_exp) ? RELEASE : GRANT;
            ptr_d   = (!bus.req[idx_q] || hold_exp) ? idx_q + 1'b1 : ptr_q;
        end else begin
            state_d = pick[IDX_W] ? GRANT : IDLE;
            idx_d   = pick[IDX_W] ? pick[IDX_W-1:0] : idx_q;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign hold_exp  = cnt_q == CNT_W'(MAX_HOLD - 1);
    assign cnt_d     = (state_q == GRANT) ? cnt_q + 1'b1 : '0;
    assign timeout_d = (state_q == GRANT) && bus.req[idx_q] && hold_exp;

    // Hold counter restarts outside GRANT; timeout pulses during the forced RELEASE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_max_hold;

    assign unused_max_hold = MAX_HOLD >= 2;
    assign hold_exp        = 1'b0;
    assign bus.timeout     = 1'b0;
`endif

    assign bus.grant_idx = idx_q;
    assign bus.grant_vld = state_q == GRANT;

    grant_decode u_dec (
        .idx_i  (idx_q),
        .en_i   (bus.grant_vld),
        .grant_o(bus.grant)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed and random checks of rr_arbiter4 against an owner/pointer model
module tb_rr_arbiter4;
    import arb4_pkg::*;

    localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter4_if bus();

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: who owns the resource (-1 = nobody), where the scan starts, how long it has held
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (!r[m_owner] || (TO_EN && m_held >= MH)) begin
                m_to    = r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_held  = 0;
                    break;
                end
            end
        end
    endtask

    // Drive req for one cycle, advance the model at the edge, return at the following negedge
    task automatic tick(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        if (rst_n) model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick(4'b0000);
        rst_n = 1'b1;
    endtask

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        check("grant", bus.grant, m_owner >= 0 ? 4'(1 << m_owner) : 4'b0000);
        check("grant_vld", bus.grant_vld, m_owner >= 0);
        if (m_owner >= 0) check("grant_idx", bus.grant_idx, m_owner);
        check("timeout", bus.timeout, m_to);
    end

    initial begin
        int got[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        bus.req = 4'b1111;
        repeat (3) tick(4'b1111);
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_vld", bus.grant_vld, 1'b0);
        check("rst_timeout", bus.timeout, 1'b0);
        check("rst_idx", bus.grant_idx, 2'd0);
        rst_n = 1'b1;
        tick(4'b0000);

        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
            tick(r);
            if (bus.grant_vld && m_owner >= 0 && m_held == 0) got.push_back(int'(bus.grant_idx));
        end
        check("order_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("order_idx", got[i], exp_order[i]);
        repeat (3) tick(4'b0000);

        tick(4'b0100);
        check("single_grant", bus.grant, 4'b0100);
        check("single_idx", bus.grant_idx, 2'd2);
        repeat (4) tick(4'b0100);
        check("single_hold", bus.grant, 4'b0100);
        tick(4'b0000);
        check("single_drop", bus.grant, 4'b0000);

        tick(4'b1001);
        check("wrap_first", bus.grant, 4'b1000);
        tick(4'b0001);
        check("wrap_gap", bus.grant_vld, 1'b0);
        tick(4'b0001);
        check("wrap_second", bus.grant, 4'b0001);
        repeat (2) tick(4'b0000);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        for (int c = 0; c < MH; c++) begin
            tick(4'b0011);
            check("to_hold", bus.grant, 4'b0001);
            check("to_quiet", bus.timeout, 1'b0);
        end
        tick(4'b0011);
        check("to_gap", bus.grant, 4'b0000);
        check("to_pulse", bus.timeout, 1'b1);
        tick(4'b0011);
        check("to_next", bus.grant, 4'b0010);
        check("to_clear", bus.timeout, 1'b0);
        repeat (2) tick(4'b0000);
`endif

        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            tick(r);
        end

        tick(4'b0010);
        tick(4'b0010);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_grant", bus.grant, 4'b0000);
        check("async_vld", bus.grant_vld, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b1000);
        check("post_rst_grant", bus.grant, 4'b1000);
        check("post_rst_idx", bus.grant_idx, 2'd3);
        tick(4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
